// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: word geometry and FSM state encoding.
package imem_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a byte stream into little-endian 32-bit words; the first byte lands in bits [7:0].
module imem_loader_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        data,
    input  logic              accept,
    input  logic              clear,
    output logic [WORD_W-1:0] word,
    output logic              word_complete
);

    logic [1:0]        count;
    logic [WORD_W-1:0] shreg;

    // word already includes the byte being accepted, so the owner can use it on the completing cycle
    always_comb begin
        word = shreg;
        if (accept) begin
            case (count)
                2'd0:    word[7:0]   = data;
                2'd1:    word[15:8]  = data;
                2'd2:    word[23:16] = data;
                default: word[31:24] = data;
            endcase
        end
    end

    assign word_complete = accept && (count == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            shreg <= '0;
        end else if (clear) begin
            count <= 2'd0;
            shreg <= '0;
        end else if (accept) begin
            count <= count + 2'd1;
            shreg <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a byte stream, verifies a trailing additive checksum,
// and keeps the core in reset until a load completes cleanly.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LEN_W     = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             cpu_reset
);

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  index;
    logic [WORD_W-1:0] sum;
    logic [WORD_W-1:0] word;
    logic              word_complete;
    logic              accept;
    logic              launch;

    assign accept = byte_valid && byte_ready;
    assign launch = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

    imem_loader_byte_assembler u_asm (
        .clock         (clock),
        .reset         (reset),
        .data          (byte_in),
        .accept        (accept),
        .clear         (launch),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            index      <= '0;
            sum        <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_reset  <= 1'b1;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (launch) begin
                        len_q      <= len;
                        index      <= '0;
                        sum        <= '0;
                        err        <= 1'b0;
                        cpu_reset  <= 1'b1;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
                        state      <= (len == '0) ? ST_CHK : ST_RECV;
                    end
                end
                // The write is issued on entry to WRITE so the strobe is registered
                ST_RECV: begin
                    if (word_complete) begin
                        state      <= ST_WRITE;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_wdata  <= word;
                        mem_addr   <= BASE_ADDR + (32'(index) << 2);
                        sum        <= sum + word;
                        index      <= index + 1'b1;
                    end
                end
                ST_WRITE: begin
                    byte_ready <= 1'b1;
                    state      <= (index == len_q) ? ST_CHK : ST_RECV;
                end
                ST_CHK: begin
                    if (word_complete) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        if (word == sum) begin
                            state     <= ST_DONE;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with hand-computed words, addresses and checksums.
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [8:0]  len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_reset;

    int total = 0;
    int bad   = 0;

    logic [31:0] we_addr[$];
    logic [31:0] we_data[$];
    int acc_cnt        = 0;
    int cyc            = 0;
    int last_acc_cyc   = 0;
    int gap_bad        = 0;
    int ready_in_write = 0;
    int done_cnt       = 0;
    logic done_err     = 1'b0;
    logic done_cpu     = 1'b0;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .LEN_W(9)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_reset  (cpu_reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observe on the falling edge, away from the active edge
    always @(negedge clock) begin
        cyc++;
        if (mem_we) begin
            we_addr.push_back(mem_addr);
            we_data.push_back(mem_wdata);
            if (cyc - last_acc_cyc != 1) gap_bad++;
            if (byte_ready) ready_in_write++;
        end
        if (byte_valid && byte_ready) begin
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_err = err;
            done_cpu = cpu_reset;
        end
    end

    task automatic pulse_start(input logic [8:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clock);
        while (!byte_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (!byte_ready) begin
            bad++;
            $display("FAIL send_byte: byte %h not accepted within 50 cycles", b);
        end
        @(posedge clock); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic wait_done(input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 100) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (done_cnt == base) begin
            bad++;
            $display("FAIL wait_done: no done pulse within 100 cycles");
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++; if (byte_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: ready=%b busy=%b want 0 0", byte_ready, busy); end
    endtask

    task automatic test_len1;
        int base;
        we_addr.delete(); we_data.delete();
        pulse_start(9'd1);
        total++; if (busy !== 1'b1 || byte_ready !== 1'b1) begin bad++; $display("FAIL len1_recv_entry: busy=%b ready=%b want 1 1", busy, byte_ready); end
        send_word(32'h0050_0093);
        base = done_cnt;
        send_word(32'h0050_0093);
        wait_done(base);
        total++; if (we_addr.size() != 1) begin bad++; $display("FAIL len1_write_count: got %0d want 1", we_addr.size()); end
        if (we_addr.size() >= 1) begin
            total++; if (we_addr[0] !== 32'h0) begin bad++; $display("FAIL len1_addr: got %h want 00000000", we_addr[0]); end
            total++; if (we_data[0] !== 32'h0050_0093) begin bad++; $display("FAIL len1_data: got %h want 00500093", we_data[0]); end
        end
        total++; if (done_err !== 1'b0 || done_cpu !== 1'b0) begin bad++; $display("FAIL len1_done_flags: err=%b cpu_reset=%b want 0 0", done_err, done_cpu); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL len1_done_pulse: got %b want 0 one cycle later", done); end
        total++; if (busy !== 1'b0 || byte_ready !== 1'b0 || cpu_reset !== 1'b0) begin bad++; $display("FAIL len1_hold: busy=%b ready=%b cpu_reset=%b want 0 0 0", busy, byte_ready, cpu_reset); end
    endtask

    task automatic test_len2_pass;
        int base;
        we_addr.delete(); we_data.delete();
        pulse_start(9'd2);
        send_word(32'h0050_0093);
        send_word(32'h00A0_0113);
        base = done_cnt;
        send_word(32'h00F0_01A6);
        wait_done(base);
        total++; if (we_addr.size() != 2) begin bad++; $display("FAIL len2_write_count: got %0d want 2", we_addr.size()); end
        if (we_addr.size() >= 2) begin
            total++; if (we_addr[0] !== 32'h0 || we_addr[1] !== 32'h4) begin bad++; $display("FAIL len2_addrs: got %h %h want 00000000 00000004", we_addr[0], we_addr[1]); end
            total++; if (we_data[0] !== 32'h0050_0093 || we_data[1] !== 32'h00A0_0113) begin bad++; $display("FAIL len2_data: got %h %h want 00500093 00a00113", we_data[0], we_data[1]); end
        end
        total++; if (done_err !== 1'b0 || done_cpu !== 1'b0) begin bad++; $display("FAIL len2_pass_flags: err=%b cpu_reset=%b want 0 0", done_err, done_cpu); end
        total++; if (ready_in_write != 0) begin bad++; $display("FAIL len2_ready_in_write: got %0d want 0", ready_in_write); end
    endtask

    task automatic test_len2_fail;
        int base;
        int acc0;
        we_addr.delete(); we_data.delete();
        pulse_start(9'd2);
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL fail_start_cpu_reset: got %b want 1", cpu_reset); end
        send_word(32'h0050_0093);
        send_word(32'h00A0_0113);
        base = done_cnt;
        send_word(32'h00F0_01A7);
        wait_done(base);
        total++; if (done_err !== 1'b1 || done_cpu !== 1'b1) begin bad++; $display("FAIL fail_done_flags: err=%b cpu_reset=%b want 1 1", done_err, done_cpu); end
        total++; if (done_cnt != base + 1) begin bad++; $display("FAIL fail_done_count: got %0d want %0d", done_cnt, base + 1); end
        acc0 = acc_cnt;
        byte_in = 8'h5A;
        byte_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        byte_valid = 1'b0;
        total++; if (acc_cnt != acc0) begin bad++; $display("FAIL error_consumes: accepted %0d want 0", acc_cnt - acc0); end
        total++; if (err !== 1'b1 || cpu_reset !== 1'b1 || byte_ready !== 1'b0) begin bad++; $display("FAIL error_hold: err=%b cpu_reset=%b ready=%b want 1 1 0", err, cpu_reset, byte_ready); end
    endtask

    task automatic test_backpressure;
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        logic [7:0] bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int k;
        int acc0;
        int base;
        we_addr.delete(); we_data.delete();
        pulse_start(9'd1);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL bp_err_cleared: got %b want 0", err); end
        acc0 = acc_cnt;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            byte_valid = (pat[i] != 0);
            if (pat[i] != 0) begin
                byte_in = bytes[k];
                k++;
            end else begin
                byte_in = 8'hEE;
            end
            @(posedge clock); #1;
        end
        byte_valid = 1'b0;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL bp_we_latency: mem_we=%b want 1 one cycle after 4th byte", mem_we); end
        @(posedge clock); #1;
        total++; if (acc_cnt - acc0 != 4) begin bad++; $display("FAIL bp_accept_count: got %0d want 4", acc_cnt - acc0); end
        total++; if (we_data.size() != 1) begin bad++; $display("FAIL bp_write_count: got %0d want 1", we_data.size()); end
        if (we_data.size() >= 1) begin
            total++; if (we_data[0] !== 32'h4433_2211 || we_addr[0] !== 32'h0) begin bad++; $display("FAIL bp_word: got %h@%h want 44332211@00000000", we_data[0], we_addr[0]); end
        end
        base = done_cnt;
        send_word(32'h4433_2211);
        wait_done(base);
        total++; if (done_err !== 1'b0 || gap_bad != 0) begin bad++; $display("FAIL bp_done: err=%b gap_errors=%0d want 0 0", done_err, gap_bad); end
    endtask

    task automatic test_start_ignored;
        int base;
        we_addr.delete(); we_data.delete();
        pulse_start(9'd2);
        send_word(32'h0050_0093);
        send_byte(8'h13);
        send_byte(8'h01);
        pulse_start(9'd5);
        total++; if (busy !== 1'b1 || byte_ready !== 1'b1) begin bad++; $display("FAIL ign_state: busy=%b ready=%b want 1 1", busy, byte_ready); end
        send_byte(8'hA0);
        send_byte(8'h00);
        base = done_cnt;
        send_word(32'h00F0_01A6);
        wait_done(base);
        total++; if (we_addr.size() != 2) begin bad++; $display("FAIL ign_write_count: got %0d want 2", we_addr.size()); end
        if (we_addr.size() >= 2) begin
            total++; if (we_addr[1] !== 32'h4 || we_data[1] !== 32'h00A0_0113) begin bad++; $display("FAIL ign_second: got %h@%h want 00a00113@00000004", we_data[1], we_addr[1]); end
        end
        total++; if (done_err !== 1'b0) begin bad++; $display("FAIL ign_err: got %b want 0", done_err); end
    endtask

    task automatic test_len0;
        int base;
        we_addr.delete(); we_data.delete();
        pulse_start(9'd0);
        total++; if (busy !== 1'b1 || byte_ready !== 1'b1 || cpu_reset !== 1'b1) begin bad++; $display("FAIL len0_entry: busy=%b ready=%b cpu_reset=%b want 1 1 1", busy, byte_ready, cpu_reset); end
        base = done_cnt;
        send_word(32'h0000_0000);
        wait_done(base);
        total++; if (we_addr.size() != 0) begin bad++; $display("FAIL len0_writes: got %0d want 0", we_addr.size()); end
        total++; if (done_err !== 1'b0 || done_cpu !== 1'b0) begin bad++; $display("FAIL len0_flags: err=%b cpu_reset=%b want 0 0", done_err, done_cpu); end
    endtask

    task automatic test_reset_midload;
        int base;
        we_addr.delete(); we_data.delete();
        pulse_start(9'd3);
        send_word(32'h1234_5678);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        #1;
        total++; if (cpu_reset !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin bad++; $display("FAIL midreset_outputs: cpu_reset=%b busy=%b ready=%b want 1 0 0", cpu_reset, busy, byte_ready); end
        total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL midreset_mem: addr=%h data=%h want 0 0", mem_addr, mem_wdata); end
        total++; if (we_addr.size() != 1) begin bad++; $display("FAIL midreset_prior_writes: got %0d want 1", we_addr.size()); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        we_addr.delete(); we_data.delete();
        pulse_start(9'd1);
        send_word(32'hDEAD_BEEF);
        base = done_cnt;
        send_word(32'hDEAD_BEEF);
        wait_done(base);
        total++; if (we_addr.size() != 1) begin bad++; $display("FAIL reload_write_count: got %0d want 1", we_addr.size()); end
        if (we_addr.size() >= 1) begin
            total++; if (we_addr[0] !== 32'h0 || we_data[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL reload_word: got %h@%h want deadbeef@00000000", we_data[0], we_addr[0]); end
        end
        total++; if (done_err !== 1'b0 || cpu_reset !== 1'b0) begin bad++; $display("FAIL reload_flags: err=%b cpu_reset=%b want 0 0", done_err, cpu_reset); end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        len        = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        test_reset();
        test_len1();
        test_len2_pass();
        test_len2_fail();
        test_backpressure();
        test_start_ignored();
        test_len0();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
